// File: rtl/mux2x4_arb.sv
// mux2x4_arb: ring/local output-port arbiter.
//
// Two ring inputs each present a flit aimed at one of four output ports. Each
// output port j also has a dedicated local requester. Every ready output picks
// at most one winner per cycle, combinationally. A transfer happens on the
// rising edge where the matching ack/grant is high.
//
// Priority for a ready output j:
//   1. local j, if it has been denied STARVE_LIMIT or more consecutive cycles
//   2. a ring input aimed at j (round-robin pointer breaks a ring-ring tie)
//   3. local j
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous reset, active low
//   i_r0_valid     ring 0 holds a flit
//   i_r0_dst[1:0]  ring 0 target output
//   i_r1_valid     ring 1 holds a flit
//   i_r1_dst[1:0]  ring 1 target output
//   i_l_req[3:0]   local j requests output j
//   i_out_ready[3:0] downstream of output j accepts this cycle
//   o_sel0..3[1:0] datapath select per output: 0 ring0, 1 ring1, 2 local
//   o_out_valid[3:0] output j carries a granted flit
//   o_r0_ack       ring 0 flit transfers at this edge
//   o_r1_ack       ring 1 flit transfers at this edge
//   o_l_grant[3:0] local j flit transfers at this edge
module mux2x4_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_r0_valid,
  input  logic [1:0] i_r0_dst,
  input  logic       i_r1_valid,
  input  logic [1:0] i_r1_dst,
  input  logic [3:0] i_l_req,
  input  logic [3:0] i_out_ready,
  output logic [1:0] o_sel0,
  output logic [1:0] o_sel1,
  output logic [1:0] o_sel2,
  output logic [1:0] o_sel3,
  output logic [3:0] o_out_valid,
  output logic       o_r0_ack,
  output logic       o_r1_ack,
  output logic [3:0] o_l_grant
);

  localparam logic [2:0] LIMIT   = 3'(STARVE_LIMIT);
  localparam logic [2:0] CNT_MAX = 3'd7;
  localparam logic [1:0] SEL_R0  = 2'd0;
  localparam logic [1:0] SEL_R1  = 2'd1;
  localparam logic [1:0] SEL_LOC = 2'd2;

  // ring priority: 0 = ring0 wins a tie, 1 = ring1 wins a tie
  logic       r_rr_ptr;
  logic [2:0] r_starve_cnt [4];

  logic [3:0] w_r0_win;
  logic [3:0] w_r1_win;
  logic [3:0] w_l_win;
  logic [1:0] w_sel [4];
  logic       w_tie;

  for (genvar j = 0; j < 4; j++) begin : g_out
    logic w_r0_hit;
    logic w_r1_hit;
    logic w_urgent;
    logic w_r0_sel;
    logic w_r1_sel;
    logic w_l_sel;

    assign w_r0_hit = i_r0_valid && (i_r0_dst == 2'(j));
    assign w_r1_hit = i_r1_valid && (i_r1_dst == 2'(j));
    assign w_urgent = i_l_req[j] && (r_starve_cnt[j] >= LIMIT);

    always_comb begin
      w_r0_sel = 1'b0;
      w_r1_sel = 1'b0;
      w_l_sel  = 1'b0;
      if (i_out_ready[j]) begin
        if (w_urgent) begin
          w_l_sel = 1'b1;
        end else if (w_r0_hit && w_r1_hit) begin
          if (r_rr_ptr) w_r1_sel = 1'b1;
          else          w_r0_sel = 1'b1;
        end else if (w_r0_hit) begin
          w_r0_sel = 1'b1;
        end else if (w_r1_hit) begin
          w_r1_sel = 1'b1;
        end else if (i_l_req[j]) begin
          w_l_sel = 1'b1;
        end
      end
    end

    assign w_r0_win[j]    = w_r0_sel;
    assign w_r1_win[j]    = w_r1_sel;
    assign w_l_win[j]     = w_l_sel;
    // no winner parks the select on local
    assign w_sel[j]       = w_r0_sel ? SEL_R0 : (w_r1_sel ? SEL_R1 : SEL_LOC);
    assign o_out_valid[j] = w_r0_sel | w_r1_sel | w_l_sel;
  end

  assign o_sel0    = w_sel[0];
  assign o_sel1    = w_sel[1];
  assign o_sel2    = w_sel[2];
  assign o_sel3    = w_sel[3];
  assign o_r0_ack  = |w_r0_win;
  assign o_r1_ack  = |w_r1_win;
  assign o_l_grant = w_l_win;

  // both rings contend for the same output; only then does priority rotate
  assign w_tie = i_r0_valid && i_r1_valid && (i_r0_dst == i_r1_dst);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr <= 1'b0;
      for (int j = 0; j < 4; j++) begin
        r_starve_cnt[j] <= 3'd0;
      end
    end else begin
      // an urgent local taking a contended output leaves both acks low,
      // so the pointer holds in that case
      if (w_tie && o_r0_ack) begin
        r_rr_ptr <= 1'b1;
      end else if (w_tie && o_r1_ack) begin
        r_rr_ptr <= 1'b0;
      end

      for (int j = 0; j < 4; j++) begin
        if (!i_l_req[j] || w_l_win[j]) begin
          r_starve_cnt[j] <= 3'd0;
        end else if (i_out_ready[j] && (r_starve_cnt[j] != CNT_MAX)) begin
          r_starve_cnt[j] <= r_starve_cnt[j] + 3'd1;
        end
      end
    end
  end

endmodule

// File: doc/mux2x4_arb.md
MUX2X4_ARB -- requirements
Module: mux2x4_arb

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, number of consecutive denied cycles before a local request becomes urgent; legal range 1..7.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 r0_valid  input  1  ring input 0 holds a flit.
REQ-005 r0_dst  input  2  output port (0..3) requested by ring input 0.
REQ-006 r1_valid  input  1  ring input 1 holds a flit.
REQ-007 r1_dst  input  2  output port requested by ring input 1.
REQ-008 l_req  input  4  bit j: local input j requests output port j.
REQ-009 out_ready  input  4  bit j: downstream of output port j accepts this cycle.
REQ-010 sel0, sel1, sel2, sel3  output  2 each  datapath select per output: 0 = ring0, 1 = ring1, 2 = local j; 3 never driven.
REQ-011 out_valid  output  4  bit j: output port j carries a granted flit this cycle.
REQ-012 r0_ack, r1_ack  output  1 each  ring input's flit transfers at this rising edge.
REQ-013 l_grant  output  4  bit j: local j's flit transfers at this rising edge.

Function
REQ-014 Grants, acks, sel and out_valid SHALL be combinational from current inputs and registered state; transfer occurs at the rising edge where grant/ack is high (zero-cycle grant latency).
REQ-015 Registered state SHALL be: rr_ptr (1 bit, ring priority; 0 = ring0 first) and starve_cnt[j] (3 bits, j = 0..3).
REQ-016 Output j with out_ready[j] = 0 SHALL grant nothing: out_valid[j] = 0, sel_j = 2, no ack/grant targeting j.
REQ-017 For output j with out_ready[j] = 1, priority SHALL be: (a) local j if l_req[j] and starve_cnt[j] >= STARVE_LIMIT; else (b) a ring input whose valid is set and dst = j, with rr_ptr breaking a tie when both target j; else (c) local j if l_req[j].
REQ-018 A ring input SHALL be acked by at most one output (its dst only); ring inputs with invalid or unready dst stay un-acked and must hold.
REQ-019 When an output has a winner, out_valid[j] = 1 and sel_j encodes the winner; with no winner, out_valid[j] = 0 and sel_j = 2.
REQ-020 rr_ptr SHALL update only on a cycle where both rings target the same ready output and a ring wins it: the ring that won loses priority (ring0 wins -> rr_ptr = 1; ring1 wins -> rr_ptr = 0). rr_ptr SHALL hold otherwise, including when an urgent local preempts the tie.
REQ-021 starve_cnt[j] SHALL clear when l_req[j] = 0 or l_grant[j] = 1; increment, saturating at 7, when l_req[j] = 1, out_ready[j] = 1 and l_grant[j] = 0; hold when out_ready[j] = 0.
REQ-022 Distinct outputs SHALL arbitrate independently in the same cycle; both rings to different ready outputs SHALL both be acked.
REQ-023 Requesters SHALL hold valid/dst/req stable until acked; the block does not latch requests.

Reset
REQ-024 While rst = 0: rr_ptr = 0 and starve_cnt = 0 immediately (asynchronous), and outputs reflect that state combinationally (with no requests: sel* = 2, out_valid = 0, acks/grants = 0).
REQ-025 Reset asserted mid-operation SHALL discard starvation history and ring priority with no partial transfer implied; first post-reset cycle arbitrates with ring0 priority.

Verification
REQ-026 Reset, all inputs 0 -> sel0..3 = 2, out_valid = 0000, all acks/grants 0.
REQ-027 r0 dst = 2, r1 dst = 2, out_ready = 1111, held 4 cycles -> grants alternate r0, r1, r0, r1; sel2 = 0, 1, 0, 1; out_valid = 0100 each cycle.
REQ-028 r0 dst = 1 held valid, l_req = 0010, STARVE_LIMIT = 4 -> r0 acked cycles 1-4 (sel1 = 0); cycle 5 l_grant = 0010, sel1 = 2, r0_ack = 0; starve_cnt[1] returns to 0.
REQ-029 r0 dst = 0, r1 dst = 3, l_req = 0110, out_ready = 1111 -> r0_ack = r1_ack = 1, l_grant = 0110, sel0 = 0, sel1 = 2, sel2 = 2, sel3 = 1, out_valid = 1111.
REQ-030 r1 dst = 3, l_req = 1000, out_ready = 0111 for 10 cycles then 1111 -> no grants for 10 cycles, starve_cnt[3] stays 0; then r1 acked first cycle.
REQ-031 starve_cnt[0] = 3 (limit 4), assert rst low for 1 cycle mid-run -> counters 0, rr_ptr 0 asynchronously; local 0 needs 4 further denials before preempting.
